// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised memory blocks.
// Holds the controller state encoding and the address-width helper.
package ram_pkg;

    // Controller states: zero-fill sequencer running, or serving requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_e;

    // Number of address bits needed to index 'value' words.
    // Evaluated at elaboration time for parameter derivation.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage core: one synchronous write port and one registered read port
// sharing a single address. Storage and the read register carry no reset,
// so the array maps onto block RAM.
module ram_array
    import ram_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Write on we, capture the addressed word on re; the read register
    // holds its value between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/param_ram.sv
// Parametrised single-port RAM with request/ready handshake, one-cycle
// registered read, a zero-fill sequencer that runs after reset and on clr,
// and out-of-range address detection for non-power-of-two depths.
module param_ram
    import ram_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  d,
    input  logic              clr,
    output logic              ready,
    output logic [WIDTH-1:0]  o,
    output logic              o_valid,
    output logic              err
);

    localparam logic [0:0]        ST_CLEAR  = CLEAR;
    localparam logic [0:0]        ST_IDLE   = IDLE;
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
    // One extra bit so addresses up to 2**ADDR_W-1 compare against DEPTH.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              o_valid_reg;
    logic              err_reg;
    logic              o_zero_reg;

    logic              clearing;
    logic              accept;
    logic              in_range;
    logic              rd_hit;
    logic              wr_hit;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    assign clearing = (state_reg == ST_CLEAR);
    // ready is a pure function of state, never of req.
    assign ready    = (state_reg == ST_IDLE);
    assign accept   = req && ready;
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign rd_hit   = accept && !we && in_range;
    assign wr_hit   = accept && we && in_range;

    // The sequencer owns the array port while clearing; otherwise the
    // requester does, with out-of-range accesses suppressed.
    always_comb begin
        mem_we    = wr_hit;
        mem_re    = rd_hit;
        mem_addr  = addr;
        mem_wdata = d;
        if (clearing) begin
            mem_we    = 1'b1;
            mem_re    = 1'b0;
            mem_addr  = cnt_reg;
            mem_wdata = '0;
        end
    end

    // Next-state logic: walk cnt through 0..DEPTH-1 then serve requests;
    // clr restarts the walk (a request in the same cycle is still accepted).
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            default: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
        endcase
    end

    // State and clear-counter registers; reset starts a fresh clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Response flags: o_valid for every accepted read, err for any accepted
    // out-of-range access; o_zero forces o to 0 after reset or a bad read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_reg <= 1'b0;
            err_reg     <= 1'b0;
            o_zero_reg  <= 1'b1;
        end else begin
            o_valid_reg <= accept && !we;
            err_reg     <= accept && !in_range;
            if (accept && !we) begin
                o_zero_reg <= !in_range;
            end
        end
    end

    ram_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign o       = o_zero_reg ? '0 : mem_rdata;
    assign o_valid = o_valid_reg;
    assign err     = err_reg;

endmodule
